ad7822_reader: RTL and testbench
================================

Name: ad7822_reader

Overview:
- Sequencer for one AD7822 8-bit parallel ADC (0–2 V range) on the rectifier board.
- Periodically pulses CONVST, waits for EOC, runs the CS/RD read cycle, and emits an 8-bit sample with a one-cycle valid strobe.
- Its o_data feeds the battery current/voltage scaling and display stage directly.
- Two instances are used, one per rectifier ADC (Ibat, Vbat).

Parameters:
- PERIOD_CYC, 100, clocks between conversion starts (500 kSa/s at 50 MHz); legal range ≥ 16.
- CONVST_CYC, 2, width of the CONVST low pulse in clocks.
- RD_CYC, 3, width of the CS/RD low window in clocks; data is latched on its last cycle.
- TIMEOUT_CYC, 64, maximum clocks spent in WAIT_EOC before abort.

Ports:
- i_clock  in  1  system clock (50 MHz)
- i_reset_n  in  1  synchronous active-low reset
- i_enable  in  1  allows new conversions to start
- i_ADC_data  in  8  ADC parallel data bus
- i_ADC_EOC_n  in  1  ADC end-of-conversion, active low, asynchronous
- o_ADC_CONVST_n  out  1  conversion start, active low
- o_ADC_CS_n  out  1  chip select, active low
- o_ADC_RD_n  out  1  read strobe, active low
- o_data  out  8  latest sample (averaged when ADC_AVG_EN is defined)
- o_valid  out  1  one-cycle strobe; o_data is new in this cycle
- o_busy  out  1  high whenever state != IDLE
- o_timeout  out  1  one-cycle pulse on an EOC timeout
- o_overrun  out  1  one-cycle pulse when a period tick arrives while busy

Behaviour:
- Reset is synchronous on i_clock when i_reset_n = 0. Reset values:
  - CONVST_n, CS_n and RD_n = 1.
  - o_data = 0; o_valid, o_busy, o_timeout and o_overrun = 0.
  - State = IDLE; all counters = 0.
- Reset mid-sequence aborts immediately. The bus is released on the next edge and no sample is emitted.
- i_ADC_EOC_n passes through a 2-flip-flop synchroniser that resets to 1. Only the synchronised value (eoc_s) is used.
- Period counter:
  - Runs freely 0..PERIOD_CYC-1 and wraps to 0.
  - tick = 1 when the count equals PERIOD_CYC-1.
  - It counts regardless of i_enable.
- FSM states: IDLE, CONV, WAIT_EOC, READ, DONE.
  - IDLE: on tick && i_enable, go to CONV.
  - CONV: CONVST_n = 0 for exactly CONVST_CYC cycles, then go to WAIT_EOC.
  - WAIT_EOC:
    - The first 2 cycles are a guard and eoc_s is ignored (covers synchroniser lag and stale EOC).
    - After the guard, eoc_s = 0 moves to READ.
    - If TIMEOUT_CYC cycles elapse in the state, go to IDLE, pulse o_timeout, and hold o_data.
  - READ: CS_n = RD_n = 0 for RD_CYC cycles. i_ADC_data is captured on the last cycle; go to DONE.
  - DONE: CS_n and RD_n return to 1. o_data is updated and o_valid = 1 for this cycle only; go to IDLE.
- Latency in DONE cycles is deterministic from the READ capture: 1 clock raw, 2 clocks with averaging.
- i_enable falling mid-sequence: the current sequence completes normally (the bus cycle is never truncated) and no new start follows.
- tick while not IDLE: the tick is dropped, o_overrun pulses, and the sequence is unaffected.
- o_data holds its value between valid strobes.
- o_busy is registered from state (= 1 in CONV, WAIT_EOC, READ and DONE).

Optional Feature:
- Macro: ADC_AVG_EN.
- Defined:
  - o_data is the mean of the last 4 captured samples: a 10-bit sum of a 4-deep shift history, shifted right by 2 (truncated).
  - The history resets to 0.
  - o_valid is suppressed until 4 samples have been captured since reset, then fires on every sample.
  - Adds 1 clock of latency.
  - Timeouts do not enter the history.
- Not defined: o_data is the raw captured byte; o_valid fires on every sample.

Decomposition:
- Package ad7822_pkg holds:
  - the state encoding (IDLE=0, CONV=1, WAIT_EOC=2, READ=3, DONE=4; 3-bit);
  - the default timing constants;
  - the guard length (2).
- Sub-module adc_avg4 (i_clock, i_reset_n, i_sample[7:0], i_strobe, o_mean[7:0], o_valid) is instantiated only under ADC_AVG_EN.

Test Plan:
- Normal read: enable = 1; the ADC model drives EOC_n low 10 cycles after CONVST rises, with data 0x80. Required: CONVST_n low for 2 cycles, CS/RD low for 3 cycles, o_data = 0x80, o_valid one cycle, period 100 cycles.
- Timeout: EOC_n held at 1. Required: o_timeout pulses 64 cycles after WAIT_EOC entry, CS_n/RD_n never fall, o_data holds its prior value, and the next conversion starts on the next tick.
- Overrun: PERIOD_CYC = 16 with EOC delay 20. Required: o_overrun pulses on every tick that arrives while busy, and no sample is corrupted.
- Disable mid-conversion: drop i_enable during WAIT_EOC. Required: the read completes with a valid sample, then CONVST_n stays 1 for at least 3 periods.
- Reset mid-READ: i_reset_n = 0 for 1 cycle while RD_n = 0. Required: all strobes return to 1 on the next edge and o_data = 0 with no valid; restart on the following tick.
- ADC_AVG_EN: samples 0x10, 0x20, 0x30, 0x40, 0x50. Required: no valid for the first 3 samples, then o_data = 0x28, then 0x38.

Source files
------------

// File: rtl/ad7822_pkg.sv
// Shared state encoding and default timing for the AD7822 sequencer.
package ad7822_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV     = 3'd1,
    WAIT_EOC = 3'd2,
    READ     = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int PERIOD_CYC_DEF  = 100;
  localparam int CONVST_CYC_DEF  = 2;
  localparam int RD_CYC_DEF      = 3;
  localparam int TIMEOUT_CYC_DEF = 64;
  localparam int GUARD_CYC       = 2;
  localparam int CNT_W           = 16;

endpackage

// File: rtl/adc_avg4.sv
// Running mean of the last four ADC samples (10-bit sum, >>2 truncated).
// Latency: 1 clock from i_strobe; o_valid suppressed until 4 samples seen.
// No backpressure: every strobe is accepted.
module adc_avg4 (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic [7:0] i_sample,
  input  logic       i_strobe,
  output logic [7:0] o_mean,
  output logic       o_valid
);

  logic [7:0] h0, h1, h2;
  logic [2:0] fill;
  logic [9:0] sum;

  // Newest sample joins the three held ones so the mean is out one clock later.
  assign sum = 10'(i_sample) + 10'(h0) + 10'(h1) + 10'(h2);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      h0      <= '0;
      h1      <= '0;
      h2      <= '0;
      fill    <= '0;
      o_mean  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_strobe) begin
        h0 <= i_sample;
        h1 <= h0;
        h2 <= h1;
        if (fill != 3'd4) fill <= fill + 3'd1;
        if (fill >= 3'd3) begin
          o_mean  <= sum[9:2];
          o_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ad7822_reader.sv
// AD7822 conversion/read sequencer; ADC_AVG_EN selects a 4-sample mean output.
// Latency: sample valid 1 clock after READ capture (2 with ADC_AVG_EN).
// No backpressure: period ticks arriving while busy are dropped and flagged on o_overrun.
module ad7822_reader
  import ad7822_pkg::*;
#(
  parameter int PERIOD_CYC  = PERIOD_CYC_DEF,
  parameter int CONVST_CYC  = CONVST_CYC_DEF,
  parameter int RD_CYC      = RD_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic [7:0] i_ADC_data,
  input  logic       i_ADC_EOC_n,
  output logic       o_ADC_CONVST_n,
  output logic       o_ADC_CS_n,
  output logic       o_ADC_RD_n,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_timeout,
  output logic       o_overrun
);

  localparam int PW = $clog2(PERIOD_CYC);

  logic [PW-1:0]    per_cnt;
  logic             tick;
  logic             eoc_m, eoc_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       cap;
  logic             cap_stb;

  assign tick = (per_cnt == PW'(PERIOD_CYC - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      per_cnt <= '0;
      eoc_m   <= 1'b1;
      eoc_s   <= 1'b1;
    end else begin
      per_cnt <= tick ? '0 : per_cnt + 1'b1;
      eoc_m   <= i_ADC_EOC_n;
      eoc_s   <= eoc_m;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      o_ADC_CONVST_n <= 1'b1;
      o_ADC_CS_n     <= 1'b1;
      o_ADC_RD_n     <= 1'b1;
      cap            <= '0;
      cap_stb        <= 1'b0;
      o_busy         <= 1'b0;
      o_timeout      <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      cap_stb   <= 1'b0;
      o_timeout <= 1'b0;
      o_overrun <= tick && (state != IDLE);
      case (state)
        IDLE: if (tick && i_enable) begin
          state          <= CONV;
          cnt            <= '0;
          o_ADC_CONVST_n <= 1'b0;
          o_busy         <= 1'b1;
        end
        CONV: if (cnt == CNT_W'(CONVST_CYC - 1)) begin
          state          <= WAIT_EOC;
          cnt            <= '0;
          o_ADC_CONVST_n <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        // The guard window hides synchroniser lag and any EOC left over from the last read.
        WAIT_EOC: if (cnt >= CNT_W'(GUARD_CYC) && !eoc_s) begin
          state      <= READ;
          cnt        <= '0;
          o_ADC_CS_n <= 1'b0;
          o_ADC_RD_n <= 1'b0;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state     <= IDLE;
          cnt       <= '0;
          o_timeout <= 1'b1;
          o_busy    <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        READ: if (cnt == CNT_W'(RD_CYC - 1)) begin
          state      <= DONE;
          cnt        <= '0;
          o_ADC_CS_n <= 1'b1;
          o_ADC_RD_n <= 1'b1;
          cap        <= i_ADC_data;
          cap_stb    <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          cnt            <= '0;
          o_ADC_CONVST_n <= 1'b1;
          o_ADC_CS_n     <= 1'b1;
          o_ADC_RD_n     <= 1'b1;
          o_busy         <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADC_AVG_EN
  adc_avg4 u_avg (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_sample  (cap),
    .i_strobe  (cap_stb),
    .o_mean    (o_data),
    .o_valid   (o_valid)
  );
`else
  assign o_data  = cap;
  assign o_valid = cap_stb;
`endif

endmodule

// File: tb/tb_ad7822_reader.sv
// Directed bench: AD7822 reader at period 100 and 16, plus the 4-sample averager unit.
module tb_ad7822_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default timing
  logic       rst_n, en, eoc_n;
  logic [7:0] adc_dat;
  logic       conv_n, cs_n, rd_n, vld, busy, tmo, ovr;
  logic [7:0] dat;

  // Instance B: short period for overrun
  logic       rst_b_n, en_b, eoc_b_n;
  logic [7:0] adc_dat_b;
  logic       conv_b_n, cs_b_n, rd_b_n, vld_b, busy_b, tmo_b, ovr_b;
  logic [7:0] dat_b;

  // Averager unit
  logic       rst_avg_n, avg_stb, avg_vld;
  logic [7:0] avg_in, avg_mean;

  ad7822_reader dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_ADC_data(adc_dat),
    .i_ADC_EOC_n(eoc_n), .o_ADC_CONVST_n(conv_n), .o_ADC_CS_n(cs_n), .o_ADC_RD_n(rd_n),
    .o_data(dat), .o_valid(vld), .o_busy(busy), .o_timeout(tmo), .o_overrun(ovr)
  );

  ad7822_reader #(.PERIOD_CYC(16)) dut_b (
    .i_clock(clk), .i_reset_n(rst_b_n), .i_enable(en_b), .i_ADC_data(adc_dat_b),
    .i_ADC_EOC_n(eoc_b_n), .o_ADC_CONVST_n(conv_b_n), .o_ADC_CS_n(cs_b_n), .o_ADC_RD_n(rd_b_n),
    .o_data(dat_b), .o_valid(vld_b), .o_busy(busy_b), .o_timeout(tmo_b), .o_overrun(ovr_b)
  );

  adc_avg4 u_avg (
    .i_clock(clk), .i_reset_n(rst_avg_n), .i_sample(avg_in), .i_strobe(avg_stb),
    .o_mean(avg_mean), .o_valid(avg_vld)
  );

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ADC models: EOC falls a fixed delay after CONVST rises, returns high once RD falls.
  int   eoc_dly = 10;
  logic eoc_hold = 1'b0;
  initial begin
    eoc_n = 1'b1;
    forever begin
      @(posedge conv_n);
      if (!eoc_hold) begin
        repeat (eoc_dly) @(posedge clk);
        #1 eoc_n = 1'b0;
        for (int k = 0; k < 12 && rd_n; k++) @(posedge clk);
        #1 eoc_n = 1'b1;
      end
    end
  end

  initial begin
    eoc_b_n = 1'b1;
    forever begin
      @(posedge conv_b_n);
      repeat (20) @(posedge clk);
      #1 eoc_b_n = 1'b0;
      for (int k = 0; k < 12 && rd_b_n; k++) @(posedge clk);
      #1 eoc_b_n = 1'b1;
    end
  end

  // Monitor A, sampled on the falling edge
  int cyc = 0, conv_fall_cyc = 0, conv_prev_fall = 0, conv_rise_cyc = 0;
  int conv_falls = 0, conv_rises = 0, rd_falls = 0, valid_cnt = 0, tmo_cnt = 0, tmo_cyc = 0;
  int conv_run = 0, rd_run = 0, cs_run = 0, vld_run = 0;
  int conv_w = 0, rd_w = 0, cs_w = 0, vld_w = 0;
  logic [7:0] vld_dat = 8'h00;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (conv_n === 1'b0) begin
      conv_run <= conv_run + 1;
      if (conv_run == 0) begin
        conv_falls     <= conv_falls + 1;
        conv_prev_fall <= conv_fall_cyc;
        conv_fall_cyc  <= cyc;
      end
    end else if (conv_run != 0) begin
      conv_w        <= conv_run;
      conv_run      <= 0;
      conv_rises    <= conv_rises + 1;
      conv_rise_cyc <= cyc;
    end
    if (rd_n === 1'b0) begin
      rd_run <= rd_run + 1;
      if (rd_run == 0) rd_falls <= rd_falls + 1;
    end else if (rd_run != 0) begin
      rd_w   <= rd_run;
      rd_run <= 0;
    end
    if (cs_n === 1'b0) cs_run <= cs_run + 1;
    else if (cs_run != 0) begin
      cs_w   <= cs_run;
      cs_run <= 0;
    end
    if (vld === 1'b1) begin
      valid_cnt <= valid_cnt + 1;
      vld_dat   <= dat;
      vld_run   <= vld_run + 1;
    end else if (vld_run != 0) begin
      vld_w   <= vld_run;
      vld_run <= 0;
    end
    if (tmo === 1'b1) begin
      tmo_cnt <= tmo_cnt + 1;
      tmo_cyc <= cyc;
    end
  end

  // Instance B: expected overrun from an independent period count and observed busy
  logic [3:0] pm_b = 4'd0;
  logic       exp_ovr_b = 1'b0;
  int ovr_b_cnt = 0, ovr_b_bad = 0, vld_b_cnt = 0, vld_b_bad = 0;

  always @(posedge clk) begin
    if (!rst_b_n) begin
      pm_b      <= 4'd0;
      exp_ovr_b <= 1'b0;
    end else begin
      pm_b      <= pm_b + 4'd1;
      exp_ovr_b <= (pm_b == 4'd15) && (busy_b === 1'b1);
    end
  end

  always @(negedge clk) begin
    if (rst_b_n) begin
      if (ovr_b !== exp_ovr_b) ovr_b_bad <= ovr_b_bad + 1;
      if (ovr_b === 1'b1) ovr_b_cnt <= ovr_b_cnt + 1;
      if (vld_b === 1'b1) begin
        vld_b_cnt <= vld_b_cnt + 1;
        if (dat_b !== 8'hA5) vld_b_bad <= vld_b_bad + 1;
      end
    end
  end

  localparam int EV_VLD = 0, EV_TMO = 1, EV_RISE = 2, EV_RD = 3;

  function automatic int evt(input int which);
    case (which)
      EV_VLD:  return valid_cnt;
      EV_TMO:  return tmo_cnt;
      EV_RISE: return conv_rises;
      default: return rd_falls;
    endcase
  endfunction

  task automatic wait_evt(input string tag, input int which, input int target, input int budget);
    int n = 0;
    while (evt(which) < target && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(evt(which) >= target), 32'd1);
  endtask

  task automatic push(input logic [7:0] v);
    avg_in  = v;
    avg_stb = 1'b1;
    step();
    avg_stb = 1'b0;
  endtask

  int base, r, v0;

  initial begin
    rst_n = 1'b0; en = 1'b0; adc_dat = 8'h00;
    rst_b_n = 1'b0; en_b = 1'b0; adc_dat_b = 8'hA5;
    rst_avg_n = 1'b0; avg_in = 8'h00; avg_stb = 1'b0;
    repeat (4) step();

    chk("rst_strobes", {conv_n, cs_n, rd_n}, 3'b111);
    chk("rst_data", dat, 8'h00);
    chk("rst_flags", {vld, busy, tmo, ovr}, 4'b0000);

    // Normal read
    rst_n = 1'b1; rst_avg_n = 1'b1;
    en = 1'b1; adc_dat = 8'h80;
    wait_evt("wait_valid1", EV_VLD, 1, 250);
    chk("norm_data", vld_dat, 8'h80);
    chk("norm_convst_w", conv_w, 2);
    chk("norm_rd_w", rd_w, 3);
    chk("norm_cs_w", cs_w, 3);
    step(); step();
    chk("norm_valid_w", vld_w, 1);
    chk("norm_hold", {vld, busy, dat}, {2'b00, 8'h80});
    wait_evt("wait_valid2", EV_VLD, 2, 250);
    chk("norm_period", conv_fall_cyc - conv_prev_fall, 100);

    // EOC timeout
    eoc_hold = 1'b1; adc_dat = 8'h5A;
    base = rd_falls; v0 = valid_cnt;
    wait_evt("wait_tmo", EV_TMO, 1, 250);
    chk("tmo_delay", tmo_cyc - conv_rise_cyc, 64);
    chk("tmo_no_read", rd_falls, base);
    chk("tmo_no_valid", valid_cnt, v0);
    chk("tmo_hold_data", dat, 8'h80);
    step();
    chk("tmo_pulse", {tmo, busy}, 2'b00);
    eoc_hold = 1'b0;
    wait_evt("wait_valid3", EV_VLD, v0 + 1, 250);
    chk("tmo_restart", conv_fall_cyc - conv_prev_fall, 100);
    chk("tmo_next_data", vld_dat, 8'h5A);

    // Disable mid-conversion
    adc_dat = 8'hC3;
    wait_evt("wait_rise", EV_RISE, conv_rises + 1, 250);
    en = 1'b0;
    wait_evt("wait_valid4", EV_VLD, v0 + 2, 100);
    chk("dis_data", vld_dat, 8'hC3);
    base = conv_falls;
    repeat (310) step();
    chk("dis_no_start", conv_falls, base);
    chk("dis_idle", {busy, conv_n}, 2'b01);

    // Reset mid-READ
    en = 1'b1; adc_dat = 8'h11;
    wait_evt("wait_rd", EV_RD, rd_falls + 1, 250);
    v0 = valid_cnt;
    rst_n = 1'b0;
    step();
    r = cyc - 1;
    rst_n = 1'b1;
    chk("rstrd_strobes", {conv_n, cs_n, rd_n}, 3'b111);
    chk("rstrd_data", dat, 8'h00);
    chk("rstrd_flags", {vld, busy}, 2'b00);
    repeat (5) step();
    chk("rstrd_no_valid", valid_cnt, v0);
    wait_evt("wait_valid5", EV_VLD, v0 + 1, 250);
    chk("rstrd_restart", conv_fall_cyc - r, 100);
    chk("rstrd_data2", vld_dat, 8'h11);

    // Overrun on the short-period instance
    rst_b_n = 1'b1; en_b = 1'b1;
    repeat (200) step();
    chk("ovr_seen", 32'(ovr_b_cnt >= 3), 32'd1);
    chk("ovr_pattern", ovr_b_bad, 0);
    chk("ovr_samples", 32'(vld_b_cnt >= 3), 32'd1);
    chk("ovr_sample_data", vld_b_bad, 0);

    // Averager: 4-deep mean, valid after fourth sample, truncating shift
    push(8'h10); chk("avg_s1", avg_vld, 1'b0);
    push(8'h20); chk("avg_s2", avg_vld, 1'b0);
    push(8'h30); chk("avg_s3", avg_vld, 1'b0);
    push(8'h40); chk("avg_s4", {avg_vld, avg_mean}, {1'b1, 8'h28});
    push(8'h50); chk("avg_s5", {avg_vld, avg_mean}, {1'b1, 8'h38});
    push(8'h01); chk("avg_trunc", {avg_vld, avg_mean}, {1'b1, 8'h30});
    step();      chk("avg_hold", {avg_vld, avg_mean}, {1'b0, 8'h30});
    push(8'hFF); push(8'hFF); push(8'hFF); push(8'hFF);
    chk("avg_full", {avg_vld, avg_mean}, {1'b1, 8'hFF});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
